// File: rtl/led_pkg.sv
// led_pkg: shared mode encodings and default widths for the LED pattern generator
package led_pkg;
  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_ON      = 2'd1;
  localparam logic [1:0] MODE_BLINK   = 2'd2;
  localparam logic [1:0] MODE_BREATHE = 2'd3;
  localparam int PER_W_DEF    = 16;
  localparam int PWM_BITS_DEF = 8;
endpackage

// File: rtl/led_channel.sv
// led_channel: one LED channel with mode/period registers, tick counter, blink phase and breathe ramp
// Ports: i_clk/i_rst_n clock and async active-low reset; i_tick prescaler tick;
//        i_wr load strobe for this channel with i_mode/i_period; i_pwm shared PWM count;
//        o_led unregistered LED level for this channel.
module led_channel import led_pkg::*; #(
  parameter int PER_W    = PER_W_DEF,
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_tick,
  input  logic                i_wr,
  input  logic [1:0]          i_mode,
  input  logic [PER_W-1:0]    i_period,
  input  logic [PWM_BITS-1:0] i_pwm,
  output logic                o_led
);
  localparam logic [PWM_BITS-1:0] BR_MAX = '1;
  logic [1:0]          r_mode;
  logic [PER_W-1:0]    r_period;
  logic [PER_W-1:0]    r_cnt;
  logic                r_phase;
  logic                r_down;
  logic [PWM_BITS-1:0] r_bright;
  logic                w_last;
  assign w_last = r_cnt == r_period - PER_W'(1);
  // A write takes priority over a coincident tick, so that tick is not counted.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_mode   <= MODE_OFF;
      r_period <= PER_W'(1);
      r_cnt    <= '0;
      r_phase  <= 1'b0;
      r_down   <= 1'b0;
      r_bright <= '0;
    end else if (i_wr) begin
      r_mode   <= i_mode;
      r_period <= (i_period == '0) ? PER_W'(1) : i_period;
      r_cnt    <= '0;
      r_phase  <= 1'b0;
      r_down   <= 1'b0;
      r_bright <= '0;
    end else if (i_tick && r_mode != MODE_OFF) begin
      r_cnt <= w_last ? '0 : r_cnt + PER_W'(1);
      if (w_last && r_mode == MODE_BLINK)
        r_phase <= ~r_phase;
      // The ramp holds one step at each end while the direction flips.
      if (w_last && r_mode == MODE_BREATHE) begin
        if (!r_down) begin
          r_down   <= r_bright == BR_MAX;
          r_bright <= (r_bright == BR_MAX) ? r_bright : r_bright + PWM_BITS'(1);
        end else begin
          r_down   <= r_bright != '0;
          r_bright <= (r_bright == '0) ? r_bright : r_bright - PWM_BITS'(1);
        end
      end
    end
  always_comb
    o_led = (r_mode == MODE_ON) ? 1'b1 :
            (r_mode == MODE_BLINK) ? r_phase :
            (r_mode == MODE_BREATHE) ? (i_pwm < r_bright) : 1'b0;
endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-channel LED pattern generator with shared prescaler and PWM counter
// Ports: i_clk/i_rst_n clock and async active-low reset; i_wr_en one-cycle write of
//        i_wr_mode/i_wr_period into channel i_wr_ch; o_tick_out registered tick pulse;
//        o_led_out registered LED drive, inverted when LED_ACTIVE_LOW is set.
module led_pattern_gen import led_pkg::*; #(
  parameter int CLK_FREQ_HZ    = 27_000_000,
  parameter int TICK_HZ        = 1000,
  parameter int N_CH           = 4,
  parameter int PER_W          = PER_W_DEF,
  parameter int PWM_BITS       = PWM_BITS_DEF,
  parameter int LED_ACTIVE_LOW = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [3:0]       i_wr_ch,
  input  logic [1:0]       i_wr_mode,
  input  logic [PER_W-1:0] i_wr_period,
  output logic             o_tick_out,
  output logic [N_CH-1:0]  o_led_out
);
  localparam int TICK_DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PRE_W    = $clog2(TICK_DIV);
  localparam logic [N_CH-1:0] LED_MASK = (LED_ACTIVE_LOW != 0) ? '1 : '0;
  if (TICK_DIV < 2) begin : g_bad_div
    $error("TICK_DIV must be at least 2");
  end
  logic [PRE_W-1:0]    r_pre_cnt;
  logic [PWM_BITS-1:0] r_pwm;
  logic                r_tick_out;
  logic [N_CH-1:0]     r_led_out;
  logic                w_tick;
  logic [N_CH-1:0]     w_led;
  assign w_tick = r_pre_cnt == PRE_W'(TICK_DIV - 1);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_pre_cnt  <= '0;
      r_pwm      <= '0;
      r_tick_out <= 1'b0;
      r_led_out  <= LED_MASK;
    end else begin
      r_pre_cnt  <= w_tick ? '0 : r_pre_cnt + PRE_W'(1);
      r_pwm      <= r_pwm + PWM_BITS'(1);
      r_tick_out <= w_tick;
      r_led_out  <= w_led ^ LED_MASK;
    end
  // Channel indices at or above N_CH match no instance, so such writes are dropped.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    led_channel #(.PER_W(PER_W), .PWM_BITS(PWM_BITS)) u_ch (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_tick   (w_tick),
      .i_wr     (i_wr_en && i_wr_ch == 4'(g)),
      .i_mode   (i_wr_mode),
      .i_period (i_wr_period),
      .i_pwm    (r_pwm),
      .o_led    (w_led[g])
    );
  end
  assign o_tick_out = r_tick_out;
  assign o_led_out  = r_led_out;
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed stimulus with a time-based reference model and literal checks
module tb_led_pattern_gen;
  logic        clk = 1'b0, rst_n = 1'b1, wr_en = 1'b0, chk_en = 1'b0;
  logic [3:0]  wr_ch = '0;
  logic [1:0]  wr_mode = '0;
  logic [15:0] wr_period = '0;
  logic        tick_out, tick_n;
  logic [3:0]  led_out, led_n;
  int          errors = 0, checks = 0;
  int          n;
  int          m_mode [4];
  int          m_per  [4];
  int          m_k    [4];
  logic [3:0]  exp_led;
  logic        exp_tick;
  int          r;

  always #5 clk = ~clk;

  led_pattern_gen #(.CLK_FREQ_HZ(1000), .TICK_HZ(100), .N_CH(4), .PER_W(16), .PWM_BITS(4), .LED_ACTIVE_LOW(0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_ch(wr_ch), .i_wr_mode(wr_mode),
    .i_wr_period(wr_period), .o_tick_out(tick_out), .o_led_out(led_out));
  led_pattern_gen #(.CLK_FREQ_HZ(1000), .TICK_HZ(100), .N_CH(4), .PER_W(16), .PWM_BITS(4), .LED_ACTIVE_LOW(1)) dut_n (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_ch(wr_ch), .i_wr_mode(wr_mode),
    .i_wr_period(wr_period), .o_tick_out(tick_n), .o_led_out(led_n));

  // LED level from ticks counted since the last write: blink phase is the parity of
  // completed periods; breathe follows a 32-step triangle with one-step holds at the ends.
  function automatic logic [3:0] model_led(input int nn);
    logic [3:0] v;
    int s, m, b;
    v = '0;
    for (int c = 0; c < 4; c++) begin
      s = m_k[c] / m_per[c];
      m = s % 32;
      b = (m < 16) ? m : 31 - m;
      v[c] = (m_mode[c] == 1) ? 1'b1 :
             (m_mode[c] == 2) ? ((s % 2) == 1) :
             (m_mode[c] == 3) ? ((nn % 16) < b) : 1'b0;
    end
    return v;
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      n        <= 0;
      exp_led  <= '0;
      exp_tick <= 1'b0;
      for (int c = 0; c < 4; c++) begin
        m_mode[c] <= 0;
        m_per[c]  <= 1;
        m_k[c]    <= 0;
      end
    end else begin
      n        <= n + 1;
      exp_tick <= (n % 10) == 9;
      exp_led  <= model_led(n);
      for (int c = 0; c < 4; c++)
        if (wr_en && int'(wr_ch) == c) begin
          m_mode[c] <= int'(wr_mode);
          m_per[c]  <= (wr_period == 0) ? 1 : int'(wr_period);
          m_k[c]    <= 0;
        end else if ((n % 10) == 9 && m_mode[c] != 0)
          m_k[c] <= m_k[c] + 1;
    end

  always @(negedge clk)
    if (rst_n && chk_en) begin
      checks++;
      if (led_out !== exp_led) begin
        errors++;
        $display("FAIL model_led t=%0t got=%b exp=%b", $time, led_out, exp_led);
      end
      checks++;
      if (led_n !== ~exp_led) begin
        errors++;
        $display("FAIL model_led_n t=%0t got=%b exp=%b", $time, led_n, ~exp_led);
      end
      checks++;
      if (tick_out !== exp_tick || tick_n !== exp_tick) begin
        errors++;
        $display("FAIL model_tick t=%0t got=%b/%b exp=%b", $time, tick_out, tick_n, exp_tick);
      end
    end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic wr(input logic [3:0] ch, input logic [1:0] md, input logic [15:0] p);
    wr_ch = ch;
    wr_mode = md;
    wr_period = p;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic align_tick();
    int c;
    c = 0;
    @(negedge clk);
    while (tick_out !== 1'b1 && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("align_tick", int'(tick_out), 1);
  endtask

  task automatic run_len(input int b, input logic v, output int len);
    len = 0;
    while (len < 100 && led_out[b] === v) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic sum_bit(input int b, input int len, output int s);
    s = 0;
    repeat (len) begin
      s += int'(led_out[b]);
      @(negedge clk);
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_led", int'(led_out), 0);
    chk("rst_led_n", int'(led_n), 15);
    chk("rst_tick", int'(tick_out), 0);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    r = 0;
    do begin @(negedge clk); r++; end while (tick_out !== 1'b1 && r < 30);
    chk("first_tick_delay", r, 10);
    r = 0;
    do begin @(negedge clk); r++; end while (tick_out !== 1'b1 && r < 30);
    chk("tick_spacing", r, 10);
    chk("idle_led_n", int'(led_n), 15);

    align_tick();
    wr(4'd1, 2'd2, 16'd3);
    run_len(1, 1'b0, r);
    chk("blink_first_low", r, 30);
    for (int i = 0; i < 4; i++) begin
      run_len(1, 1'b1, r);
      chk("blink_high", r, 30);
      run_len(1, 1'b0, r);
      chk("blink_low", r, 30);
    end

    align_tick();
    wr(4'd2, 2'd3, 16'd1);
    sum_bit(2, 10, r);
    chk("breathe_zero_start", r, 0);
    repeat (140) @(negedge clk);
    sum_bit(2, 16, r);
    chk("breathe_peak_duty", r, 15);
    repeat (144) @(negedge clk);
    sum_bit(2, 20, r);
    chk("breathe_zero_hold", r, 0);

    wr(4'd0, 2'd1, 16'd5);
    chk("on_first_clk", int'(led_out[0]), 0);
    @(negedge clk);
    chk("on_second_clk", int'(led_out[0]), 1);
    wr(4'd7, 2'd0, 16'd0);
    sum_bit(0, 5, r);
    chk("invalid_write_ignored", r, 5);

    align_tick();
    wr(4'd3, 2'd2, 16'd0);
    sum_bit(3, 10, r);
    chk("p0_low_tick", r, 0);
    sum_bit(3, 10, r);
    chk("p0_high_tick", r, 10);
    repeat (8) @(negedge clk);
    wr(4'd3, 2'd2, 16'd0);
    @(negedge clk);
    sum_bit(3, 10, r);
    chk("tick_write_restart", r, 0);
    chk("tick_write_toggle", int'(led_out[3]), 1);

    repeat (37) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_led", int'(led_out), 0);
    chk("async_rst_led_n", int'(led_n), 15);
    chk("async_rst_tick", int'(tick_out), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    r = 0;
    repeat (60) begin
      @(negedge clk);
      r += int'(|led_out);
    end
    chk("post_rst_all_off", r, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
